// File: rtl/rf_scan_snapshot_ctrl.sv
// rf_scan_snapshot_ctrl
// Captures all register-file observation words in a single cycle on request
// and streams them out one word per beat over a valid/ready interface.
// Optional build macro RF_SCAN_CHECKSUM_EN appends one extra beat that carries
// the XOR of all captured words. The port list is the same in both builds.
module rf_scan_snapshot_ctrl #(
  parameter int NUM_WORDS  = 9,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] scan_words_i,
  input  logic                            req_i,
  input  logic                            abort_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic [IDX_WIDTH-1:0]            out_idx_o,
  output logic                            out_last_o,
  output logic                            busy_o,
  output logic                            done_o
);

`ifdef RF_SCAN_CHECKSUM_EN
  localparam int NUM_BEATS = NUM_WORDS + 1;
`else
  localparam int NUM_BEATS = NUM_WORDS;
`endif
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] snap_q [NUM_WORDS];
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  handshake;
  logic                  is_last;
  logic                  load;

  assign handshake = (state_q == S_STREAM) && out_ready_i;
  assign is_last   = (idx_q == LAST_IDX);
  assign load      = (state_q == S_IDLE) && req_i;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of always-block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over a same-cycle handshake.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_i) state_d = S_STREAM;
      S_STREAM: begin
        if (abort_i)                     state_d = S_IDLE;
        else if (handshake && is_last)   state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Snapshot registers: loaded atomically only on IDLE->STREAM.
  // NOTE: the snapshot array is reset explicitly because the idle-state data
  // value is defined as zero; a small register bank, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_WORDS; k++) snap_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_WORDS; k++)
        snap_q[k] <= scan_words_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Beat index: cleared on load, advanced per accepted non-last beat, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (load) begin
      idx_q <= '0;
    end else if (handshake && !abort_i && !is_last) begin
      idx_q <= idx_q + 1'b1;
    end
  end

`ifdef RF_SCAN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;

  // XOR-fold of the captured words, driven straight from the snapshot regs.
  always_comb begin
    checksum = '0;
    for (int k = 0; k < NUM_WORDS; k++) checksum = checksum ^ snap_q[k];
  end
`endif

  // Output decode: everything is zero outside STREAM except busy/done.
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_idx_o   = '0;
    out_last_o  = 1'b0;
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    if (state_q == S_STREAM) begin
      out_valid_o = 1'b1;
      out_idx_o   = idx_q;
      out_last_o  = is_last;
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (idx_q == IDX_WIDTH'(k)) out_data_o = snap_q[k];
      end
`ifdef RF_SCAN_CHECKSUM_EN
      if (idx_q == IDX_WIDTH'(NUM_WORDS)) out_data_o = checksum;
`endif
    end
  end

endmodule

// File: tb/tb_rf_scan_snapshot_ctrl.sv
// Testbench for rf_scan_snapshot_ctrl: directed stimulus with a scoreboard
// queue of expected beats and a separate monitor that pops on each transfer.
// Honours RF_SCAN_CHECKSUM_EN the same way as the design.
module tb_rf_scan_snapshot_ctrl;

  localparam int NW = 9;
  localparam int DW = 32;
  localparam int IW = 4;
`ifdef RF_SCAN_CHECKSUM_EN
  localparam int NB = NW + 1;
`else
  localparam int NB = NW;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NW*DW-1:0] scan_words;
  logic             req, abort, out_ready;
  logic             out_valid, out_last, busy, done;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_idx;

  logic [DW-1:0] w [NW];
  beat_t         sb_q [$];
  int            exp_done = 0;
  int            checks   = 0;
  int            errors   = 0;

  rf_scan_snapshot_ctrl #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_words_i(scan_words),
    .req_i       (req),
    .abort_i     (abort),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k = base + k; drives the packed bus and keeps the bench copy.
  task automatic set_words(input logic [DW-1:0] base);
    for (int k = 0; k < NW; k++) begin
      w[k] = base + DW'(k);
      scan_words[k*DW +: DW] = w[k];
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input int i, input logic l);
    beat_t b;
    b.data = d;
    b.idx  = IW'(i);
    b.last = l;
    sb_q.push_back(b);
  endtask

  // Expected beats of one complete stream from the current bench words.
  task automatic push_stream();
    logic [DW-1:0] chk;
    chk = '0;
    for (int k = 0; k < NW; k++) begin
      push_beat(w[k], k, (NB == NW) && (k == NW - 1));
      chk = chk ^ w[k];
    end
    if (NB > NW) push_beat(chk, NW, 1'b1);
    exp_done++;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, DW'(n < 200), 1);
    check({name, "_queue_empty"}, DW'(sb_q.size()), 0);
  endtask

  // Monitor: every transferred beat (abort suppresses the transfer) is popped
  // and compared; every done pulse must have been expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready && !abort) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got idx %0d data %h, none expected", out_idx, out_data);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
            errors++;
            $display("FAIL beat: got idx %0d data %h last %b expected idx %0d data %h last %b",
                     out_idx, out_data, out_last, e.idx, e.data, e.last);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_done == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done 1 expected 0 at %0t", $time);
        end else begin
          exp_done--;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; abort = 1'b0; out_ready = 1'b0; scan_words = '0;
    #23 rst_n = 1'b1;

    // Reset state held through 5 idle cycles.
    repeat (5) tick();
    check("rst_valid", DW'(out_valid), 0);
    check("rst_data",  out_data,       0);
    check("rst_idx",   DW'(out_idx),   0);
    check("rst_last",  DW'(out_last),  0);
    check("rst_busy",  DW'(busy),      0);
    check("rst_done",  DW'(done),      0);

    // Back-to-back stream with ready tied high; exact cycle timing.
    set_words(32'hA5A5_0000);
    out_ready = 1'b1;
    push_stream();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("b2b_lat_valid", DW'(out_valid), 1);
    check("b2b_lat_idx",   DW'(out_idx),   0);
    for (int c = 1; c < NB; c++) begin
      tick();
      check("b2b_idx", DW'(out_idx), DW'(c));
    end
    check("b2b_last", DW'(out_last), 1);
    tick();
    check("b2b_done",      DW'(done),      1);
    check("b2b_done_vld",  DW'(out_valid), 0);
    tick();
    check("b2b_idle_busy", DW'(busy), 0);
    wait_drain("b2b");

    // Backpressure on beat 2 while the observed words change underneath.
    set_words(32'hC0DE_0100);
    push_stream();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    check("bp_hold_idx", DW'(out_idx), 2);
    check("bp_hold_data", out_data, 32'hC0DE_0102);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) for (int k = 0; k < NW; k++) scan_words[k*DW +: DW] = 32'hDEAD_0000 + DW'(k);
      check("bp_hold_idx",  DW'(out_idx), 2);
      check("bp_hold_data", out_data, 32'hC0DE_0102);
    end
    out_ready = 1'b1;
    wait_drain("bp");

    // Abort together with the beat-4 handshake: beats 0..3 only, no done.
    set_words(32'h0BAD_0000);
    for (int k = 0; k < 4; k++) push_beat(w[k], k, 1'b0);
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (4) tick();
    check("ab_idx4", DW'(out_idx), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", DW'(out_valid), 0);
    check("ab_busy",  DW'(busy),      0);
    check("ab_done",  DW'(done),      0);
    repeat (3) tick();
    check("ab_queue_empty", DW'(sb_q.size()), 0);
    set_words(32'h7777_0010);
    push_stream();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("ab_restart_valid", DW'(out_valid), 1);
    check("ab_restart_idx",   DW'(out_idx),   0);
    wait_drain("ab");

    // req_i held high: one full stream, then a second only after IDLE.
    set_words(32'h5A5A_0000);
    push_stream();
    push_stream();
    req = 1'b1;
    tick();
    for (int c = 2; c <= NB + 1; c++) begin
      check("ir_busy", DW'(busy), 1);
      tick();
    end
    check("ir_done", DW'(done), 1);
    tick();
    check("ir_idle_busy", DW'(busy), 0);
    tick();
    req = 1'b0;
    check("ir_second_valid", DW'(out_valid), 1);
    check("ir_second_idx",   DW'(out_idx),   0);
    wait_drain("ir");

    // Asynchronous reset during beat 3; no done afterwards.
    set_words(32'h3C3C_0000);
    for (int k = 0; k < 3; k++) push_beat(w[k], k, 1'b0);
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (3) tick();
    check("mr_idx3", DW'(out_idx), 3);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", DW'(out_valid), 0);
    check("mr_data",  out_data,       0);
    check("mr_idx",   DW'(out_idx),   0);
    check("mr_last",  DW'(out_last),  0);
    check("mr_busy",  DW'(busy),      0);
    check("mr_done",  DW'(done),      0);
    repeat (2) tick();
    #3 rst_n = 1'b1;
    repeat (NB + 3) tick();
    check("mr_after_valid", DW'(out_valid), 0);
    check("mr_after_busy",  DW'(busy),      0);
    check("mr_queue_empty", DW'(sb_q.size()), 0);

    check("final_done_count", DW'(exp_done), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
